// File: rtl/pwm_dac_multi.sv
// Multi-channel PWM DAC: a shared prescaler drives an edge- or centre-aligned counter,
// and double-buffered duty registers swap only at period boundaries.
module pwm_dac_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                enable,
  input  logic                mode,
  input  logic [1:0]          freq_sel,
  input  logic                wr_en,
  input  logic [3:0]          wr_chan,
  input  logic [WIDTH-1:0]    wr_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick
);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  dir_t             dir, dir_nxt;
  logic             en_q;
  logic [5:0]       presc, presc_nxt, presc_max;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic             act_mode;
  logic [1:0]       act_fsel;
  logic             tick;
  logic             boundary;
  logic [WIDTH-1:0] shadow [CHANNELS];
  logic [WIDTH-1:0] active [CHANNELS];

  always_comb begin
    case (act_fsel)
      2'd0:    presc_max = 6'd0;
      2'd1:    presc_max = 6'd3;
      2'd2:    presc_max = 6'd15;
      default: presc_max = 6'd63;
    endcase
  end

  assign tick = (presc == presc_max);

  // The first enabled clock after reset or a disable also counts as a boundary.
  assign boundary = enable &&
                    (!en_q || (tick && (act_mode ? (dir == DOWN && cnt == CNT_ONE)
                                                 : (cnt == CNT_MAX))));

  always_comb begin
    presc_nxt = presc;
    cnt_nxt   = cnt;
    dir_nxt   = dir;
    if (!enable || boundary) begin
      presc_nxt = '0;
      cnt_nxt   = '0;
      dir_nxt   = UP;
    end else if (tick) begin
      presc_nxt = '0;
      if (!act_mode) begin
        cnt_nxt = cnt + CNT_ONE;
      end else if (dir == UP) begin
        if (cnt == CNT_MAX) begin
          cnt_nxt = CNT_MAX - CNT_ONE;
          dir_nxt = DOWN;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end else begin
        cnt_nxt = cnt - CNT_ONE;
      end
    end else begin
      presc_nxt = presc + 6'd1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      en_q        <= 1'b0;
      presc       <= '0;
      cnt         <= '0;
      dir         <= UP;
      act_mode    <= 1'b0;
      act_fsel    <= '0;
      pwm_out     <= '0;
      period_tick <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      en_q        <= enable;
      presc       <= presc_nxt;
      cnt         <= cnt_nxt;
      dir         <= dir_nxt;
      period_tick <= boundary;
      if (boundary) begin
        act_mode <= mode;
        act_fsel <= freq_sel;
      end
      // A write landing on a boundary clock misses that transfer: active takes the old shadow.
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_out[i] <= enable && (cnt < active[i]);
        if (boundary) active[i] <= shadow[i];
        if (wr_en && wr_chan == 4'(i)) shadow[i] <= wr_data;
      end
    end
  end
endmodule
